// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_alu
//  Brief    : Execute-stage ALU with valid/ready handshakes; shifts iterate
//             SHIFT_STEP bits per cycle instead of using a barrel shifter.
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_alu #(
   parameter int DATA_WIDTH = 32,
   parameter int SHIFT_STEP = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            Operation,
   input  logic [DATA_WIDTH-1:0] SrcA,
   input  logic [DATA_WIDTH-1:0] SrcB,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] ALUResult,
   output logic                  Zero
);

   localparam int              SHW    = $clog2(DATA_WIDTH);
   localparam logic [SHW-1:0]  C_STEP = SHW'(SHIFT_STEP);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0011;
   localparam logic [3:0] OP_SLL = 4'b0100;
   localparam logic [3:0] OP_SRL = 4'b0101;
   localparam logic [3:0] OP_SRA = 4'b0111;
   localparam logic [3:0] OP_EQ  = 4'b1000;
   localparam logic [3:0] OP_SLT = 4'b1100;

   logic [1:0]            state_q,  state_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic [DATA_WIDTH-1:0] acc_q,    acc_d;
   logic [SHW-1:0]        rem_q,    rem_d;
   logic [3:0]            op_q,     op_d;
   logic                  sign_q,   sign_d;

   logic                  w_accept;
   logic                  w_is_shift;
   logic [SHW-1:0]        w_shamt;
   logic [DATA_WIDTH-1:0] w_alu;
   logic [SHW-1:0]        w_step;
   logic                  w_last;
   logic [DATA_WIDTH-1:0] w_shifted;

   assign w_accept   = in_valid && in_ready;
   assign w_shamt    = SrcB[SHW-1:0];
   assign w_is_shift = (Operation == OP_SLL) || (Operation == OP_SRL) ||
                       (Operation == OP_SRA);

   // Single-cycle result; undefined codes fall through to zero.
   always_comb begin
      w_alu = '0;
      case (Operation)
         OP_AND:  w_alu = SrcA & SrcB;
         OP_OR:   w_alu = SrcA | SrcB;
         OP_ADD:  w_alu = SrcA + SrcB;
         OP_SUB:  w_alu = SrcA - SrcB;
         OP_EQ:   w_alu = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
         OP_SLT:  w_alu = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
         default: w_alu = '0;
      endcase
   end

   assign w_step = (rem_q > C_STEP) ? C_STEP : rem_q;
   assign w_last = (rem_q <= C_STEP);

   // SRA fills from the sign captured at accept, not from the running accumulator.
   always_comb begin
      w_shifted = acc_q;
      case (op_q)
         OP_SLL:  w_shifted = acc_q << w_step;
         OP_SRL:  w_shifted = acc_q >> w_step;
         OP_SRA:  w_shifted = (acc_q >> w_step) |
                              (sign_q ? ~({DATA_WIDTH{1'b1}} >> w_step) : '0);
         default: w_shifted = acc_q;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               state_d = (w_is_shift && (w_shamt != '0)) ? S_SHIFT : S_DONE;
            end
         end
         S_SHIFT: begin
            if (w_last) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values
   always_comb begin
      result_d = result_q;
      acc_d    = acc_q;
      rem_d    = rem_q;
      op_d     = op_q;
      sign_d   = sign_q;
      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               if (!w_is_shift) begin
                  result_d = w_alu;
               end else if (w_shamt == '0) begin
                  result_d = SrcA;
               end else begin
                  acc_d  = SrcA;
                  rem_d  = w_shamt;
                  op_d   = Operation;
                  sign_d = SrcA[DATA_WIDTH-1];
               end
            end
         end
         S_SHIFT: begin
            acc_d = w_shifted;
            rem_d = rem_q - w_step;
            if (w_last) begin
               result_d = w_shifted;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         result_q <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
         op_q     <= '0;
         sign_q   <= 1'b0;
      end else begin
         result_q <= result_d;
         acc_q    <= acc_d;
         rem_q    <= rem_d;
         op_q     <= op_d;
         sign_q   <= sign_d;
      end
   end

   // Outputs; in_ready is gated by reset so it drops the instant reset asserts.
   always_comb begin
      in_ready  = (state_q == S_IDLE) && reset;
      out_valid = (state_q == S_DONE);
      ALUResult = result_q;
      Zero      = (result_q == '0);
   end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_alu
//  Brief    : Scoreboard bench for multicycle_alu (DATA_WIDTH=32, SHIFT_STEP=1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_alu;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  Operation;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] ALUResult;
   logic        Zero;

   int          n_checks;
   int          n_fail;
   logic [31:0] exp_q[$];
   int          lat_q[$];

   multicycle_alu #(
      .DATA_WIDTH (32),
      .SHIFT_STEP (1)
   ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Operation (Operation),
      .SrcA      (SrcA),
      .SrcB      (SrcB),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ALUResult (ALUResult),
      .Zero      (Zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [31:0] r;
      case (op)
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b0010: r = a + b;
         4'b0011: r = a - b;
         4'b0100: r = a << b[4:0];
         4'b0101: r = a >> b[4:0];
         4'b0111: r = $signed(a) >>> b[4:0];
         4'b1000: r = (a == b) ? 32'd1 : 32'd0;
         4'b1100: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   function automatic int lat_model(input logic [3:0] op, input logic [31:0] b);
      if ((op == 4'b0100 || op == 4'b0101 || op == 4'b0111) && b[4:0] != 5'd0)
         return int'(b[4:0]) + 1;
      return 1;
   endfunction

   // One transaction with out_ready=1; latency counts the accept edge as 1.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input int elat);
      int          lat;
      logic [31:0] e;
      int          el;
      @(negedge clk);
      Operation = op;
      SrcA      = a;
      SrcB      = b;
      in_valid  = 1'b1;
      exp_q.push_back(er);
      lat_q.push_back(elat);
      check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
         @(posedge clk);
         #1;
         lat++;
      end
      if (!out_valid) begin
         check({tag, "_timeout"}, 32'd0, 32'd1);
         return;
      end
      e  = exp_q.pop_front();
      el = lat_q.pop_front();
      check({tag, "_result"}, ALUResult, e);
      check({tag, "_zero"}, {31'd0, Zero}, {31'd0, (e == 32'd0)});
      check({tag, "_latency"}, lat, el);
      check({tag, "_rdy_done"}, {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      check({tag, "_ovalid_drop"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      logic [3:0]  ops [0:10];
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      n_checks  = 0;
      n_fail    = 0;
      ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
              4'b0111, 4'b1000, 4'b1100, 4'b0110, 4'b1111};
      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      Operation = 4'd0;
      SrcA      = 32'd0;
      SrcB      = 32'd0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_result", ALUResult, 32'd0);
      check("rst_zero", {31'd0, Zero}, 32'd1);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rel_in_ready", {31'd0, in_ready}, 32'd1);

      run_op("add",     4'b0010, 32'd5, 32'd7, 32'd12, 1);
      run_op("sub_neg", 4'b0011, 32'd3, 32'd5, 32'hFFFF_FFFE, 1);
      run_op("sub_eq",  4'b0011, 32'd9, 32'd9, 32'd0, 1);
      run_op("sll31",   4'b0100, 32'd1, 32'd31, 32'h8000_0000, 32);
      run_op("sra4",    4'b0111, 32'h8000_0000, 32'd4, 32'hF800_0000, 5);
      run_op("srl4",    4'b0101, 32'h8000_0000, 32'd4, 32'h0800_0000, 5);
      run_op("sll0",    4'b0100, 32'hDEAD_BEEF, 32'd32, 32'hDEAD_BEEF, 1);
      run_op("sra0",    4'b0111, 32'h8765_4321, 32'd0, 32'h8765_4321, 1);
      run_op("slt",     4'b1100, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
      run_op("eq_hit",  4'b1000, 32'h1234, 32'h1234, 32'd1, 1);
      run_op("eq_miss", 4'b1000, 32'h1234, 32'h1235, 32'd0, 1);
      run_op("undef",   4'b1111, 32'd5, 32'd6, 32'd0, 1);
      run_op("and",     4'b0000, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000, 1);
      run_op("or",      4'b0001, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1);

      for (int i = 0; i < 12; i++) begin
         op = ops[$urandom_range(0, 10)];
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 3) == 0) b = a;
         run_op("rand", op, a, b, model(op, a, b), lat_model(op, b));
      end

      // Backpressure: result must hold while a new request waits.
      @(negedge clk);
      out_ready = 1'b0;
      Operation = 4'b0010;
      SrcA      = 32'h10;
      SrcB      = 32'h20;
      in_valid  = 1'b1;
      exp_q.push_back(32'h30);
      @(posedge clk);
      #1;
      Operation = 4'b0011;
      SrcA      = 32'd1;
      SrcB      = 32'd1;
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp_hold", ALUResult, exp_q[0]);
         check("bp_valid_hold", {31'd0, out_valid}, 32'd1);
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp_final", ALUResult, exp_q.pop_front());
      @(posedge clk);
      #1;
      check("bp_drop", {31'd0, out_valid}, 32'd0);
      check("bp_ready_back", {31'd0, in_ready}, 32'd1);

      // Reset pulse in the middle of a 20-step shift.
      @(negedge clk);
      Operation = 4'b0100;
      SrcA      = 32'd1;
      SrcB      = 32'd20;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("mid_busy", {31'd0, out_valid}, 32'd0);
      reset = 1'b0;
      #1;
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_result", ALUResult, 32'd0);
      check("mid_rst_zero", {31'd0, Zero}, 32'd1);
      check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("mid_rel_ready", {31'd0, in_ready}, 32'd1);
      run_op("post_rst_add", 4'b0010, 32'd100, 32'd23, 32'd123, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
